fetch_stage: RTL



---
 rtl/fetch_stage.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage with IF/ID register and a req/ack imem port.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_f,
  input  logic              en_d,
  input  logic              rst_d,
  input  logic [1:0]        pc_src,
  input  logic [31:0]       jr_target,
  input  logic              halt,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ack,
  output logic [31:0]       inst_d,
  output logic [31:0]       pc_plus4_d,
  output logic              valid_d,
  output logic [31:0]       pc_f,
  output logic              halted,
  output logic [PERF_W-1:0] fetch_cnt,
  output logic [PERF_W-1:0] bubble_cnt
);
  typedef enum logic [1:0] {FETCH, HOLD, DRAIN, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d_n, pc4_q, pc4_d, hold_q, hold_d, pend_pc_q, pend_pc_d;
  logic        req_q, req_d, vld_q, vld_d, pend_q, pend_d;

  logic        ack_v, redirect, halt_v, deliver;
  logic [31:0] target, word, pc_inc;

  always_comb begin
    // ack only counts once a request has actually been on the bus
    ack_v    = imem_ack & req_q;
    redirect = en_f & (pc_src != 2'd0);
    halt_v   = halt & vld_q & en_d;
    pc_inc   = pc_q + 32'd4;
    case (pc_src)
      2'd1:    target = {pc4_q[31:28], inst_q[25:0], 2'b00};
      2'd2:    target = jr_target;
      default: target = pc4_q + {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
    endcase

    state_d   = state_q;
    pc_d      = pc_q;
    hold_d    = hold_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    deliver   = 1'b0;
    word      = imem_rdata;

    case (state_q)
      FETCH: begin
        if (halt_v) begin
          state_d = (req_q && !ack_v) ? DRAIN : HALT;
          pend_d  = 1'b0;
        end else if (redirect) begin
          if (req_q && !ack_v) begin
            pend_d    = 1'b1;
            pend_pc_d = target;
          end else begin
            pc_d   = target;
            pend_d = 1'b0;
          end
        end else if (ack_v) begin
          if (pend_q) begin
            pc_d   = pend_pc_q;
            pend_d = 1'b0;
          end else if (en_f) begin
            deliver = 1'b1;
            pc_d    = pc_inc;
          end else begin
            hold_d  = imem_rdata;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (halt_v) begin
          state_d = HALT;
        end else if (redirect) begin
          pc_d    = target;
          state_d = FETCH;
        end else if (en_f) begin
          deliver = 1'b1;
          word    = hold_q;
          pc_d    = pc_inc;
          state_d = FETCH;
        end
      end
      DRAIN: if (ack_v) state_d = HALT;
      default: ;
    endcase

    inst_d_n = inst_q;
    pc4_d    = pc4_q;
    vld_d    = vld_q;
    if (en_d) begin
      if (deliver && !rst_d) begin
        inst_d_n = word;
        pc4_d    = pc_inc;
        vld_d    = 1'b1;
      end else begin
        inst_d_n = 32'd0;
        pc4_d    = 32'd0;
        vld_d    = 1'b0;
      end
    end

    req_d = (state_d == FETCH) || (state_d == DRAIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      req_q     <= 1'b0;
      inst_q    <= 32'd0;
      pc4_q     <= 32'd0;
      vld_q     <= 1'b0;
      hold_q    <= 32'd0;
      pend_q    <= 1'b0;
      pend_pc_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_q     <= req_d;
      inst_q    <= inst_d_n;
      pc4_q     <= pc4_d;
      vld_q     <= vld_d;
      hold_q    <= hold_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign pc_f       = pc_q;
  assign inst_d     = inst_q;
  assign pc_plus4_d = pc4_q;
  assign valid_d    = vld_q;
  assign halted     = (state_q == HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [PERF_W-1:0] fetch_cnt_q, fetch_cnt_d, bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (en_d) begin
      if (vld_d) fetch_cnt_d  = fetch_cnt_q + 1'b1;
      else       bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  assign fetch_cnt  = '0;
  assign bubble_cnt = '0;
`endif
endmodule
